alu_exec_stage: RTL

- Registered execute stage that accepts ALU operations from the decode/issue logic and computes ADD, SUB, MUL, AND, OR, XOR, NOT and PASS.
- Results go to the register-file writeback, using valid/ready handshakes on both sides.
- Contains a 2-entry input FIFO, a small FSM, and a configurable multi-cycle latency for MUL (timing relief on the shift-add path).
- Sits between the instruction decoder and writeback in each processor of the multiprocessor architecture.

---
 rtl/alu_pkg.sv | 13 +
 rtl/alu_exec_stage_op_fifo2.sv | 36 +++
 rtl/alu_exec_stage.sv | 108 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state encoding and default width for the ALU execute stage
package alu_pkg;
    localparam int WIDTH_DEF = 8;
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_NOT  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
endpackage

// File: rtl/alu_exec_stage_op_fifo2.sv
// op_fifo2: two-entry FIFO with 1-bit wrapping pointers and an occupancy count
module op_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic wp, rp, do_push, do_pop;
    assign full    = count == 2'd2;
    assign empty   = count == 2'd0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp];
    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= 1'b0;
            rp    <= 1'b0;
            count <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wp] <= din;
                wp      <= ~wp;
            end
            if (do_pop) rp <= ~rp;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end
endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: buffered, registered ALU execute stage with multi-cycle MUL and valid/ready on both sides
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int RD_W       = 3,
    parameter int MUL_CYCLES = 3,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [RD_W-1:0]  in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [RD_W-1:0]  out_rd,
    output logic             out_zero,
    output logic             out_carry,
    output logic             busy
);
    localparam int PW = 3 + 2*WIDTH + RD_W;
    function automatic logic [2*WIDTH-1:0] mul_sa(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] p;
        p = '0;
        for (int i = 0; i < WIDTH; i++)
            if (b[i]) p = p + ({{WIDTH{1'b0}}, a} << i);
        return p;
    endfunction
    state_t state;
    logic [2:0] cnt, op_q, f_op;
    logic [WIDTH-1:0] a_q, b_q, f_a, f_b, res;
    logic [RD_W-1:0] rd_q, f_rd;
    logic [PW-1:0] f_dout;
    logic [1:0] fifo_count;
    logic fifo_full, fifo_empty, pop, cy;
    logic [WIDTH:0] sum, diff;
    logic [2*WIDTH-1:0] prod;
    assign in_ready = !fifo_full;
    assign pop      = state == S_IDLE && fifo_count != 2'd0;
    assign busy     = state != S_IDLE || !fifo_empty;
    assign {f_op, f_a, f_b, f_rd} = f_dout;
    op_fifo2 #(.W(PW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid && in_ready),
        .pop   (pop),
        .din   ({in_op, in_a, in_b, in_rd}),
        .dout  (f_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );
    always_comb begin
        sum  = {1'b0, a_q} + {1'b0, b_q};
        diff = {1'b0, a_q} - {1'b0, b_q};
        prod = mul_sa(a_q, b_q);
        res  = op_q == OP_ADD ? sum[WIDTH-1:0] :
               op_q == OP_SUB ? diff[WIDTH-1:0] :
               op_q == OP_MUL ? prod[WIDTH-1:0] :
               op_q == OP_AND ? a_q & b_q :
               op_q == OP_OR  ? a_q | b_q :
               op_q == OP_XOR ? a_q ^ b_q :
               op_q == OP_NOT ? ~a_q : a_q;
        cy   = op_q == OP_ADD ? sum[WIDTH] :
               op_q == OP_SUB ? diff[WIDTH] :
               op_q == OP_MUL ? |prod[2*WIDTH-1:WIDTH] : 1'b0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_rd     <= '0;
            out_zero   <= 1'b0;
            out_carry  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (pop) begin
                    op_q  <= f_op;
                    a_q   <= f_a;
                    b_q   <= f_b;
                    rd_q  <= f_rd;
                    cnt   <= f_op == OP_MUL ? 3'(MUL_CYCLES - 1) : 3'd0;
                    state <= S_EXEC;
                end
                S_EXEC: if (cnt == 3'd0) begin
                    out_result <= res;
                    out_rd     <= rd_q;
                    out_zero   <= res == '0;
                    out_carry  <= cy;
                    out_valid  <= 1'b1;
                    state      <= S_DONE;
                end else cnt <= cnt - 3'd1;
                S_DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
